serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 170 +++++++++++++++++
 tb/tb_serial_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Write-only UART transmitter (8N1, LSB first) fed by a small byte FIFO,
// with a DATA push register and a STATUS register on a 4-bit offset bus.
module serial_tx #(
  parameter int CLK_DIV = 868,
  parameter int DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [NW-1:0] CNT_DEPTH = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;
  logic            ovf;
  logic            full, empty, busy;
  logic            data_wr, stat_wr, push, pop;
  logic [7:0]      count_byte;
  logic            din_unused;

  assign full       = (count == CNT_DEPTH);
  assign empty      = (count == '0);
  assign busy       = (state != IDLE);
  assign data_wr    = sel && we && (addr == 4'h0);
  assign stat_wr    = sel && we && (addr == 4'h4);
  assign push       = data_wr && !full;
  assign count_byte = 8'(count);
  assign din_unused = ^din[31:8];

  // Register reads ignore sel so the bus mux can sample dout freely.
  always_comb begin
    dout = '0;
    if (addr == 4'h4) begin
      dout = {16'b0, count_byte, 4'b0, ovf, empty, full, busy};
    end
  end

  // Next-state logic; tx_n is registered so the line never glitches.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          cnt_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 1'b1;
          tx_n  = 1'b0;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            idx_n   = idx + 3'd1;
            tx_n    = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
          tx_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Full is judged before the edge, so a same-edge pop does not save the write.
      if (stat_wr && din[3]) begin
        ovf <= 1'b0;
      end else if (data_wr && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din[7:0];
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-level reference model predicts tx and STATUS every
// cycle, and an independent line decoder checks transmitted bytes against exp_q.
module tb_serial_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  addr = 4'h4;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        tx;

  always #5 clk = ~clk;

  serial_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we),
    .addr(addr), .din(din), .dout(dout), .tx(tx)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mq[$];
  int          cyc = 0;
  int          fstart = -1000;
  logic [7:0]  cur = 8'h00;
  bit          ovf = 1'b0;
  bit          rx_act = 1'b0;
  int          rx_ph = 0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  rx_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line level expected for the current cycle from the frame start time.
  function automatic logic model_tx();
    int k;
    k = cyc - fstart;
    if (k >= 0 && k < FRAME) begin
      if (k < CLK_DIV) return 1'b0;
      if (k < 9 * CLK_DIV) return cur[(k - CLK_DIV) / CLK_DIV];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_dout(input logic [3:0] a);
    logic [31:0] r;
    int k;
    r = '0;
    k = cyc - fstart;
    if (a == 4'h4) begin
      r[0]    = (k >= 0 && k < FRAME);
      r[1]    = (mq.size() == DEPTH);
      r[2]    = (mq.size() == 0);
      r[3]    = ovf;
      r[15:8] = 8'(mq.size());
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    fstart = -1000;
    ovf    = 1'b0;
    rx_act = 1'b0;
    rx_ph  = 0;
  endtask

  // One clock edge of the reference: a frame may start whenever the previous
  // one has used up its FRAME cycles and a byte is waiting.
  task automatic model_edge();
    bit wd, ws, pre_full;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      wd = sel && we && (addr == 4'h0);
      ws = sel && we && (addr == 4'h4);
      pre_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && cyc >= fstart + FRAME) begin
        cur    = mq.pop_front();
        fstart = cyc;
        exp_q.push_back(cur);
      end
      if (wd) begin
        if (pre_full) ovf = 1'b1;
        else mq.push_back(din[7:0]);
      end
      if (ws && din[3]) ovf = 1'b0;
    end
  endtask

  // Independent receiver: mid-bit sampling of the DUT line.
  task automatic rx_sample();
    logic [31:0] e;
    if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_ph  = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph >= CLK_DIV + CLK_DIV / 2 && rx_ph < 9 * CLK_DIV &&
          (rx_ph - CLK_DIV - CLK_DIV / 2) % CLK_DIV == 0)
        rx_byte[(rx_ph - CLK_DIV - CLK_DIV / 2) / CLK_DIV] = tx;
      if (rx_ph == 9 * CLK_DIV + CLK_DIV / 2) begin
        check("rx_stop", 32'(tx), 32'd1);
        rx_log.push_back(rx_byte);
        e = 'x;
        if (exp_q.size() != 0) e = {24'b0, exp_q.pop_front()};
        check("rx_byte", {24'b0, rx_byte}, e);
      end
      if (rx_ph == FRAME - 1) rx_act = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check("tx", 32'(tx), 32'(model_tx()));
    check("dout", dout, model_dout(addr));
    rx_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h4, 32'h0);
  endtask

  task automatic mid_reset();
    addr = 4'h4; sel = 1'b0; we = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("tx_async_rst", 32'(tx), 32'd1);
    check("status_in_rst", dout, 32'h0000_0004);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("tx_reset", 32'(tx), 32'd1);
    check("status_reset", dout, 32'h0000_0004);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    rst = 1'b0;
    idle(3);

    // Single 0x55 frame; upper din bits must be ignored.
    rx_log.delete();
    step(1'b1, 1'b1, 4'h0, 32'hFFFF_FF55);
    idle(45);
    check("n_030", rx_log.size(), 1);
    check("byte_030", {24'b0, rx_log[0]}, 32'h55);

    // Back-to-back frames with no idle gap.
    rx_log.delete();
    step(1'b1, 1'b1, 4'h0, 32'h01);
    step(1'b1, 1'b1, 4'h0, 32'h80);
    idle(85);
    check("n_031", rx_log.size(), 2);
    check("byte_031a", {24'b0, rx_log[0]}, 32'h01);
    check("byte_031b", {24'b0, rx_log[1]}, 32'h80);

    // Overflow: six writes into a 4-deep FIFO while idle.
    rx_log.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h0, 32'hA0 + i);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    check("status_032", dout, 32'h0000_040B);
    step(1'b1, 1'b1, 4'h4, 32'h8);
    check("status_clr", dout, 32'h0000_0403);
    idle(210);
    check("n_032", rx_log.size(), 5);
    for (int i = 0; i < 5; i++) check("byte_032", {24'b0, rx_log[i]}, 32'hA0 + i);

    // Reset in the middle of a data bit that is low.
    rx_log.delete();
    step(1'b1, 1'b1, 4'h0, 32'h00);
    step(1'b1, 1'b1, 4'h0, 32'hC3);
    idle(14);
    check("tx_before_rst", 32'(tx), 32'd0);
    mid_reset();
    step(1'b0, 1'b0, 4'h4, 32'h0);
    check("status_033", dout, 32'h0000_0004);
    idle(60);
    check("n_033", rx_log.size(), 0);

    // Reserved offsets read zero and ignore writes.
    rx_log.delete();
    step(1'b0, 1'b0, 4'h0, 32'h0);
    check("rd_0", dout, 32'h0);
    step(1'b0, 1'b0, 4'h8, 32'h0);
    check("rd_8", dout, 32'h0);
    step(1'b0, 1'b0, 4'hC, 32'h0);
    check("rd_c", dout, 32'h0);
    step(1'b1, 1'b1, 4'h0, 32'h5A);
    step(1'b1, 1'b1, 4'h0, 32'h5B);
    step(1'b1, 1'b1, 4'h8, 32'hFF);
    step(1'b1, 1'b1, 4'h8, 32'h08);
    step(1'b0, 1'b0, 4'h4, 32'h0);
    check("status_034", dout, 32'h0000_0101);
    idle(90);
    check("n_034", rx_log.size(), 2);
    check("byte_034a", {24'b0, rx_log[0]}, 32'h5A);
    check("byte_034b", {24'b0, rx_log[1]}, 32'h5B);

    // Randomized traffic: light load, then heavy load with overflows.
    for (int i = 0; i < 3000; i++) begin
      int mode, wr_pct;
      wr_pct = (i < 1500) ? 2 : 6;
      mode = $urandom_range(0, 99);
      if (i == 1000) mid_reset();
      if (mode < wr_pct)
        step(1'b1, 1'b1, 4'h0, $urandom);
      else if (mode == wr_pct)
        step(1'b1, 1'b1, 4'h4, $urandom);
      else if (mode < wr_pct + 5)
        step(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
             4'($urandom_range(0, 15)), $urandom);
      else
        step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
    end
    idle(250);
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_rx_idle", 32'(rx_act), 32'd0);
    check("drain_status", dout & 32'h0000_FF07, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
